datapath_param: RTL and testbench
=================================

Name: datapath_param

Overview:
- Parametrised successor to the single-accumulator processor datapath.
- Contains a REG_COUNT-entry general register file, a flag-producing ALU with a result latch, a loadable program counter, MAR and IR.
- Replaces the combinational divide/modulo BCD path with a multi-cycle double-dabble converter using a start/busy/done handshake.
- Sits between the control unit (strobes) and the memory data bus; its BCD output feeds the existing Display decoder.

Parameters:
- DATA_W, 8, data bus, register, ALU and result width.
- REG_COUNT, 4, general registers (power of two, ≥2).
- ADDR_W, 8, PC and MAR width.
- BCD_DIGITS, 4, BCD output digits; must satisfy 10^BCD_DIGITS > 2^DATA_W − 1.
- BCD_AUTO, 0, 1 = every alu_latch also starts a BCD conversion.

Ports:
- clock in 1: single clock, rising edge.
- reset in 1: synchronous, active-high.
- reg_sel in log2(REG_COUNT): register file index (operand A and write target).
- reg_write in 1: reg_file[reg_sel] <= data_bus_in.
- alu_op in 4: ALU operation.
- alu_latch in 1: capture ALU result and flags.
- result_oe in 1: drive result register onto data_bus_out.
- data_bus_in in DATA_W: bus input, ALU operand B.
- data_bus_out out DATA_W: result register when result_oe=1, else 0.
- flags out 3: {N,Z,C} latched with result.
- pc_inc in 1: PC + 1.
- pc_load in 1: PC <= data_bus_in[ADDR_W-1:0], zero-extended if needed.
- pc_count out ADDR_W: program counter.
- mar_write in 1 / mar_value out ADDR_W: memory address register.
- ir_write in 1 / ir_value out DATA_W: instruction register.
- bcd_start in 1: request conversion of the result register.
- bcd_busy out 1: conversion in progress.
- bcd_done out 1: one-cycle pulse when bcd_digits update.
- bcd_digits out 4*BCD_DIGITS: packed BCD; digit 0 (units) in the LSBs.

Behaviour:
- Reset (synchronous): all registers, PC, MAR, IR, result, flags and bcd_digits go to 0; bcd_busy=0, bcd_done=0. Any conversion in progress is aborted.
- Reset during a conversion: no bcd_done pulse is produced.
- ALU, combinational. A = reg_file[reg_sel], B = data_bus_in, all arithmetic modulo 2^DATA_W.
  - 0 ADD: C = carry out.
  - 1 SUB (A−B): C = borrow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SHL A by 1: C = A[MSB].
  - 7 SHR A by 1 (logical): C = A[0].
  - 8 PASS B.
  - 9–15 PASS A.
  - C=0 for all logic and pass operations.
  - N = result MSB; Z = (result == 0).
- Result latency: on an alu_latch edge, result and flags update and are visible the next cycle. Without alu_latch they hold.
- Register-file read/write collision: a reg_write and alu_latch in the same cycle use the pre-write register value for the ALU.
- data_bus_out is combinational from result_oe and the result register.
- PC priority: pc_load > pc_inc > hold. Increment wraps from 2^ADDR_W−1 to 0.
- MAR/IR: load from data_bus_in on their write strobe, otherwise hold.
- BCD converter, start:
  - Triggered by bcd_start, or by alu_latch when BCD_AUTO=1.
  - Accepted only when bcd_busy=0; ignored while busy (no queueing).
  - Captures the result register value present at the start edge. If alu_latch falls in the same cycle, the old value is captured.
- BCD converter, conversion:
  - Conversion state machine: IDLE → SHIFT (DATA_W cycles) → IDLE.
  - bcd_busy is high for exactly DATA_W cycles starting the cycle after the start edge.
  - Each SHIFT cycle adds 3 to every BCD nibble ≥5, then shifts left one bit with the next source MSB shifted in.
- BCD converter, completion:
  - bcd_digits load on the final shift edge.
  - bcd_done is high for exactly the one cycle after that edge.
  - A new start is accepted in that done cycle; back-to-back conversion is allowed.
  - bcd_digits hold their previous value throughout a conversion, so there are no partial values.

Decomposition:
- Shared package datapath_pkg:
  - ALU opcode constants (ALU_ADD … ALU_PASS_B).
  - Flag bit index constants.
  - BCD converter state enum.
- Natural sub-module bcd_serial_converter:
  - Parameters DATA_W and BCD_DIGITS.
  - Ports clock, reset, start, value, busy, done, digits.
- The ALU stays inline as combinational logic.

Test Plan:
- Reset then idle: every output is 0; bcd_busy=0.
- Write R1=200, alu_op=ADD with bus=100, alu_latch → result 44 (0x2C), flags N=0 Z=0 C=1. With result_oe=1, data_bus_out=44.
- R2=5, SUB with bus=5 → result 0, Z=1 C=0. Then SUB with bus=6 → 255, N=1 C=1.
- Result=255, bcd_start pulse: bcd_busy high for 8 cycles; then bcd_digits=0x0255 and bcd_done pulses once. A second start issued while busy is ignored.
- BCD_AUTO=1: latch 99 → digits 0x0099 with no bcd_start. Reset asserted mid-conversion → digits=0, busy=0, no done.
- PC: pc_load 254, pc_inc ×2 → 0. pc_load and pc_inc together with bus=17 → PC=17.

Source files
------------

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_pkg
//  Description : Shared ALU opcodes, flag bit positions and BCD converter
//                state encoding for the parametrised datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    // ALU operation codes; 9..15 fall through to PASS A
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_NOT    = 4'd5;
    localparam logic [3:0] ALU_SHL    = 4'd6;
    localparam logic [3:0] ALU_SHR    = 4'd7;
    localparam logic [3:0] ALU_PASS_B = 4'd8;

    // Bit positions inside the {N,Z,C} flag vector
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // BCD converter states
    typedef logic [0:0] bcd_state_t;
    localparam bcd_state_t BCD_IDLE  = 1'b0;
    localparam bcd_state_t BCD_SHIFT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/datapath_param_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_converter
//  Description : Multi-cycle double-dabble binary to packed BCD converter
//                with start/busy/done handshake. One source bit per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_converter
    import datapath_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BCD_DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_W-1:0]       value,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] digits
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DATA_W - 1);

    bcd_state_t        r_state;
    logic [DATA_W-1:0] r_src;
    logic [BCD_W-1:0]  r_work;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic [BCD_W-1:0]  r_digits;

    logic [BCD_W-1:0]  w_adj;
    logic [BCD_W-1:0]  w_next;

    // Add-3 correction on every nibble that would overflow past 9 when doubled
    generate
        for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_nib
            assign w_adj[4*i +: 4] = (r_work[4*i +: 4] >= 4'd5) ?
                                     (r_work[4*i +: 4] + 4'd3) : r_work[4*i +: 4];
        end
    endgenerate

    assign w_next = {w_adj[BCD_W-2:0], r_src[DATA_W-1]};

    // Conversion sequencer; result only published on the final shift so
    // downstream never sees a partial value
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= BCD_IDLE;
            r_src    <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_digits <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                BCD_IDLE: begin
                    if (start) begin
                        r_src   <= value;
                        r_work  <= '0;
                        r_cnt   <= '0;
                        r_state <= BCD_SHIFT;
                    end
                end
                BCD_SHIFT: begin
                    r_src  <= r_src << 1;
                    r_work <= w_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last) begin
                        r_digits <= w_next;
                        r_done   <= 1'b1;
                        r_state  <= BCD_IDLE;
                    end
                end
                default: r_state <= BCD_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == BCD_SHIFT);
    assign done   = r_done;
    assign digits = r_digits;

endmodule
`default_nettype wire

// File: rtl/datapath_param.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_param
//  Description : Parametrised processor datapath: register file, flagged ALU
//                with result latch, PC, MAR, IR and a serial BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_param
    import datapath_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_COUNT  = 4,
    parameter int ADDR_W     = 8,
    parameter int BCD_DIGITS = 4,
    parameter bit BCD_AUTO   = 1'b0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [$clog2(REG_COUNT)-1:0] reg_sel,
    input  logic                         reg_write,
    input  logic [3:0]                   alu_op,
    input  logic                         alu_latch,
    input  logic                         result_oe,
    input  logic [DATA_W-1:0]            data_bus_in,
    output logic [DATA_W-1:0]            data_bus_out,
    output logic [2:0]                   flags,
    input  logic                         pc_inc,
    input  logic                         pc_load,
    output logic [ADDR_W-1:0]            pc_count,
    input  logic                         mar_write,
    output logic [ADDR_W-1:0]            mar_value,
    input  logic                         ir_write,
    output logic [DATA_W-1:0]            ir_value,
    input  logic                         bcd_start,
    output logic                         bcd_busy,
    output logic                         bcd_done,
    output logic [4*BCD_DIGITS-1:0]      bcd_digits
);

    logic [DATA_W-1:0] r_regs [REG_COUNT];
    logic [DATA_W-1:0] r_result;
    logic [2:0]        r_flags;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_res;
    logic              w_carry;
    logic [2:0]        w_flags;
    logic [ADDR_W-1:0] w_bus_addr;
    logic              w_bcd_start;

    // Bus value as an address: truncate or zero-extend to ADDR_W
    generate
        if (ADDR_W <= DATA_W) begin : g_addr_trunc
            assign w_bus_addr = data_bus_in[ADDR_W-1:0];
        end else begin : g_addr_zext
            assign w_bus_addr = {{(ADDR_W-DATA_W){1'b0}}, data_bus_in};
        end
    endgenerate

    assign w_a    = r_regs[reg_sel];
    assign w_b    = data_bus_in;
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    // ALU; the extra top bit of the subtract is the borrow
    always_comb begin
        w_res   = w_a;
        w_carry = 1'b0;
        case (alu_op)
            ALU_ADD:    {w_carry, w_res} = w_sum;
            ALU_SUB:    {w_carry, w_res} = w_diff;
            ALU_AND:    w_res = w_a & w_b;
            ALU_OR:     w_res = w_a | w_b;
            ALU_XOR:    w_res = w_a ^ w_b;
            ALU_NOT:    w_res = ~w_a;
            ALU_SHL: begin
                w_res   = {w_a[DATA_W-2:0], 1'b0};
                w_carry = w_a[DATA_W-1];
            end
            ALU_SHR: begin
                w_res   = {1'b0, w_a[DATA_W-1:1]};
                w_carry = w_a[0];
            end
            ALU_PASS_B: w_res = w_b;
            default:    w_res = w_a;
        endcase
        w_flags         = 3'b000;
        w_flags[FLAG_N] = w_res[DATA_W-1];
        w_flags[FLAG_Z] = (w_res == '0);
        w_flags[FLAG_C] = w_carry;
    end

    // Register file write; ALU reads the pre-write value in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else if (reg_write) begin
            r_regs[reg_sel] <= data_bus_in;
        end
    end

    // Result and flag latch
    always_ff @(posedge clock) begin
        if (reset) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (alu_latch) begin
            r_result <= w_res;
            r_flags  <= w_flags;
        end
    end

    // Program counter: load beats increment
    always_ff @(posedge clock) begin
        if (reset)        r_pc <= '0;
        else if (pc_load) r_pc <= w_bus_addr;
        else if (pc_inc)  r_pc <= r_pc + ADDR_W'(1);
    end

    // Memory address and instruction registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mar <= '0;
            r_ir  <= '0;
        end else begin
            if (mar_write) r_mar <= w_bus_addr;
            if (ir_write)  r_ir  <= data_bus_in;
        end
    end

    // Converter sees the result register before any same-edge latch
    assign w_bcd_start = bcd_start | (BCD_AUTO & alu_latch);

    bcd_serial_converter #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd (
        .clock  (clock),
        .reset  (reset),
        .start  (w_bcd_start),
        .value  (r_result),
        .busy   (bcd_busy),
        .done   (bcd_done),
        .digits (bcd_digits)
    );

    assign data_bus_out = result_oe ? r_result : '0;
    assign flags        = r_flags;
    assign pc_count     = r_pc;
    assign mar_value    = r_mar;
    assign ir_value     = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_datapath_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_param
//  Description : Scoreboard bench for datapath_param, default instance plus
//                an auto-convert instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Default instance signals
    logic       reset = 1'b1;
    logic [1:0] reg_sel = '0;
    logic       reg_write = 0, alu_latch = 0, result_oe = 1;
    logic [3:0] alu_op = '0;
    logic [7:0] data_bus_in = '0, data_bus_out;
    logic [2:0] flags;
    logic       pc_inc = 0, pc_load = 0, mar_write = 0, ir_write = 0, bcd_start = 0;
    logic [7:0] pc_count, mar_value, ir_value;
    logic       bcd_busy, bcd_done;
    logic [15:0] bcd_digits;

    // Auto-convert instance signals
    logic       a_reset = 1'b1;
    logic [1:0] a_reg_sel = '0;
    logic       a_reg_write = 0, a_alu_latch = 0;
    logic [3:0] a_alu_op = '0;
    logic [7:0] a_data_bus_in = '0, a_data_bus_out;
    logic [2:0] a_flags;
    logic [7:0] a_pc_count, a_mar_value, a_ir_value;
    logic       a_bcd_busy, a_bcd_done;
    logic [15:0] a_bcd_digits;

    datapath_param dut (
        .clock(clock), .reset(reset), .reg_sel(reg_sel), .reg_write(reg_write),
        .alu_op(alu_op), .alu_latch(alu_latch), .result_oe(result_oe),
        .data_bus_in(data_bus_in), .data_bus_out(data_bus_out), .flags(flags),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_count(pc_count),
        .mar_write(mar_write), .mar_value(mar_value), .ir_write(ir_write),
        .ir_value(ir_value), .bcd_start(bcd_start), .bcd_busy(bcd_busy),
        .bcd_done(bcd_done), .bcd_digits(bcd_digits)
    );

    datapath_param #(.BCD_AUTO(1'b1)) dut_auto (
        .clock(clock), .reset(a_reset), .reg_sel(a_reg_sel), .reg_write(a_reg_write),
        .alu_op(a_alu_op), .alu_latch(a_alu_latch), .result_oe(1'b1),
        .data_bus_in(a_data_bus_in), .data_bus_out(a_data_bus_out), .flags(a_flags),
        .pc_inc(1'b0), .pc_load(1'b0), .pc_count(a_pc_count),
        .mar_write(1'b0), .mar_value(a_mar_value), .ir_write(1'b0),
        .ir_value(a_ir_value), .bcd_start(1'b0), .bcd_busy(a_bcd_busy),
        .bcd_done(a_bcd_done), .bcd_digits(a_bcd_digits)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_res[$];
    logic [2:0]  exp_flg[$];
    logic [15:0] exp_bcd[$];
    logic [15:0] a_exp_bcd[$];
    logic        latch_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] val);
        reg_sel = sel; data_bus_in = val; reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic alu_exp(input logic [3:0] op, input logic [7:0] bus,
                           input logic [7:0] er, input logic [2:0] ef);
        alu_op = op; data_bus_in = bus; alu_latch = 1'b1;
        exp_res.push_back(er);
        exp_flg.push_back(ef);
        tick();
        alu_latch = 1'b0;
    endtask

    // Result/flags are valid the cycle after an alu_latch edge
    always @(posedge clock) latch_d <= alu_latch;

    always @(negedge clock) begin
        if (latch_d) begin
            if (exp_res.size() == 0) chk("alu_unexpected_latch", 1, 0);
            else begin
                chk("alu_result", data_bus_out, exp_res.pop_front());
                chk("alu_flags", flags, exp_flg.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (bcd_done) begin
            if (exp_bcd.size() == 0) chk("bcd_unexpected_done", 1, 0);
            else chk("bcd_digits", bcd_digits, exp_bcd.pop_front());
        end
    end

    always @(negedge clock) begin
        if (a_bcd_done) begin
            if (a_exp_bcd.size() == 0) chk("auto_bcd_unexpected_done", 1, 0);
            else chk("auto_bcd_digits", a_bcd_digits, a_exp_bcd.pop_front());
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int busy_cnt;
        int dones;

        // Reset
        tick(); tick();
        reset = 1'b0; a_reset = 1'b0;
        tick();
        chk("rst_bus_out", data_bus_out, 0);
        chk("rst_flags", flags, 0);
        chk("rst_pc", pc_count, 0);
        chk("rst_mar", mar_value, 0);
        chk("rst_ir", ir_value, 0);
        chk("rst_busy", bcd_busy, 0);
        chk("rst_done", bcd_done, 0);
        chk("rst_digits", bcd_digits, 0);

        // ALU operations on R1 = 200 (0xC8)
        wr(2'd1, 8'd200);
        reg_sel = 2'd1;
        alu_exp(4'd0, 8'd100, 8'd44, 3'b001);
        result_oe = 1'b0; #1;
        chk("bus_out_disabled", data_bus_out, 0);
        result_oe = 1'b1;
        alu_exp(4'd6, 8'h00, 8'd144, 3'b101);
        alu_exp(4'd7, 8'h00, 8'd100, 3'b000);
        alu_exp(4'd4, 8'hFF, 8'h37, 3'b000);
        alu_exp(4'd2, 8'h0F, 8'h08, 3'b000);
        alu_exp(4'd3, 8'h07, 8'hCF, 3'b100);
        alu_exp(4'd5, 8'h00, 8'h37, 3'b000);
        alu_exp(4'd8, 8'h80, 8'h80, 3'b100);
        alu_exp(4'd12, 8'h80, 8'd200, 3'b100);

        // Subtraction on R2 = 5
        wr(2'd2, 8'd5);
        reg_sel = 2'd2;
        alu_exp(4'd1, 8'd5, 8'd0, 3'b010);
        alu_exp(4'd1, 8'd6, 8'd255, 3'b101);

        // Same-cycle write and latch uses old R3 (0)
        reg_sel = 2'd3; data_bus_in = 8'd7; reg_write = 1'b1;
        alu_op = 4'd9; alu_latch = 1'b1;
        exp_res.push_back(8'd0); exp_flg.push_back(3'b010);
        tick();
        reg_write = 1'b0; alu_latch = 1'b0;
        alu_exp(4'd9, 8'h00, 8'd7, 3'b000);

        // BCD conversion of 255 with an ignored start while busy
        reg_sel = 2'd2;
        alu_exp(4'd1, 8'd6, 8'd255, 3'b101);
        bcd_start = 1'b1; exp_bcd.push_back(16'h0255);
        tick();
        bcd_start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bcd_busy) busy_cnt++;
            if (i == 2) bcd_start = 1'b1;
            if (i == 3) bcd_start = 1'b0;
            if (i == 4) chk("bcd_hold_during_conv", bcd_digits, 0);
            tick();
        end
        chk("bcd_busy_cycles", busy_cnt, 8);
        chk("bcd_idle_after", bcd_busy, 0);

        // Start together with a latch captures the old result, then back-to-back
        reg_sel = 2'd1; alu_op = 4'd9; alu_latch = 1'b1; bcd_start = 1'b1;
        exp_res.push_back(8'd200); exp_flg.push_back(3'b100);
        exp_bcd.push_back(16'h0255);
        tick();
        alu_latch = 1'b0; bcd_start = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bcd_done) begin ok = 1; break; end
            tick();
        end
        chk("bcd_done_timeout_1", ok, 1);
        bcd_start = 1'b1; exp_bcd.push_back(16'h0200);
        tick();
        bcd_start = 1'b0;
        chk("bcd_b2b_busy", bcd_busy, 1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bcd_done) begin ok = 1; break; end
            tick();
        end
        chk("bcd_done_timeout_2", ok, 1);
        tick(); tick();

        // PC, MAR, IR
        pc_load = 1'b1; data_bus_in = 8'd254;
        tick();
        pc_load = 1'b0;
        chk("pc_load", pc_count, 254);
        pc_inc = 1'b1;
        tick();
        chk("pc_inc", pc_count, 255);
        tick();
        chk("pc_wrap", pc_count, 0);
        pc_load = 1'b1; data_bus_in = 8'd17;
        tick();
        pc_load = 1'b0; pc_inc = 1'b0;
        chk("pc_load_priority", pc_count, 17);
        tick();
        chk("pc_hold", pc_count, 17);
        mar_write = 1'b1; data_bus_in = 8'h5A;
        tick();
        mar_write = 1'b0;
        ir_write = 1'b1; data_bus_in = 8'hA5;
        tick();
        ir_write = 1'b0;
        chk("mar_value", mar_value, 8'h5A);
        chk("ir_value", ir_value, 8'hA5);

        // Auto-convert instance: each latch converts the pre-latch result
        a_reg_sel = 2'd0; a_data_bus_in = 8'd99; a_reg_write = 1'b1;
        tick();
        a_reg_write = 1'b0;
        a_alu_op = 4'd9;
        a_alu_latch = 1'b1; a_exp_bcd.push_back(16'h0000);
        tick();
        a_alu_latch = 1'b0;
        chk("auto_busy_started", a_bcd_busy, 1);
        chk("auto_result", a_data_bus_out, 8'd99);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_bcd_done) begin ok = 1; break; end
            tick();
        end
        chk("auto_done_timeout_1", ok, 1);
        tick();
        a_alu_latch = 1'b1; a_exp_bcd.push_back(16'h0099);
        tick();
        a_alu_latch = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_bcd_done) begin ok = 1; break; end
            tick();
        end
        chk("auto_done_timeout_2", ok, 1);
        chk("auto_digits_99", a_bcd_digits, 16'h0099);
        tick();

        // Reset mid-conversion: abort, clear, no done
        a_alu_latch = 1'b1;
        tick();
        a_alu_latch = 1'b0;
        tick(); tick(); tick();
        chk("auto_busy_mid", a_bcd_busy, 1);
        chk("auto_digits_hold", a_bcd_digits, 16'h0099);
        a_reset = 1'b1;
        tick();
        chk("auto_rst_digits", a_bcd_digits, 0);
        chk("auto_rst_busy", a_bcd_busy, 0);
        chk("auto_rst_result", a_data_bus_out, 0);
        a_reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (a_bcd_done) dones++;
            tick();
        end
        chk("auto_no_done_after_reset", dones, 0);

        chk("alu_queue_empty", exp_res.size(), 0);
        chk("bcd_queue_empty", exp_bcd.size(), 0);
        chk("auto_bcd_queue_empty", a_exp_bcd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
